// File: rtl/ram_bist_master.sv
// ram_bist_master
// Avalon-MM initiator that fills a word-addressed RAM with the pattern
// (seed + address) and/or reads it back and compares. One transfer per cycle.
// The word range runs from base_addr to last_addr inclusive and wraps from all-ones to 0.
//
// Optional feature macro: RAM_BIST_ERR_COUNT_EN
//   defined   : adds a 16-bit saturating err_count output, and verify scans the whole range
//   undefined : verify stops issuing reads at the first mismatch
//
// state  | meaning
// IDLE   | waiting for start
// WRITE  | one write per cycle, pattern data
// READ   | one read per cycle, expected address pipelined
// DRAIN  | no transfers; waits for the in-flight read data to be compared
// DONE   | one-cycle done pulse
module ram_bist_master #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     last_addr,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     err_addr,
    output logic [DATA_W-1:0]     err_data,
`ifdef RAM_BIST_ERR_COUNT_EN
    output logic [15:0]           err_count,
`endif
    output logic [ADDR_W-1:0]     address,
    output logic [DATA_W/8-1:0]   byteenable,
    output logic                  chipselect,
    output logic                  write,
    output logic [DATA_W-1:0]     writedata,
    output logic                  clken,
    input  logic [DATA_W-1:0]     readdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

`ifdef RAM_BIST_ERR_COUNT_EN
    localparam bit STOP_ON_ERR = 1'b0;
`else
    localparam bit STOP_ON_ERR = 1'b1;
`endif

    state_t                r_state;
    logic [1:0]            r_mode;
    logic [ADDR_W-1:0]     r_base;
    logic [ADDR_W-1:0]     r_last;
    logic [DATA_W-1:0]     r_seed;
    logic [ADDR_W-1:0]     r_remain;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_cs;
    logic                  r_write;
    logic [DATA_W/8-1:0]   r_be;
    logic [ADDR_W-1:0]     r_err_addr;
    logic [DATA_W-1:0]     r_err_data;
    logic [DRN_W-1:0]      r_drain;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [ADDR_W-1:0]     r_pipe_addr [READ_LATENCY];
`ifdef RAM_BIST_ERR_COUNT_EN
    logic [15:0]           r_err_count;
`endif

    logic [ADDR_W-1:0]     w_addr_inc;
    logic [ADDR_W-1:0]     w_cmp_addr;
    logic [DATA_W-1:0]     w_exp;
    logic                  w_mismatch;
    logic                  w_stop;

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                  input logic [ADDR_W-1:0] a);
        return s + {{(DATA_W-ADDR_W){1'b0}}, a};
    endfunction

    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_cmp_addr = r_pipe_addr[READ_LATENCY-1];
    assign w_exp      = pattern(r_seed, w_cmp_addr);
    assign w_mismatch = r_pipe_vld[READ_LATENCY-1] && (readdata != w_exp);
    assign w_stop     = STOP_ON_ERR && w_mismatch;

    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign err_addr   = r_err_addr;
    assign err_data   = r_err_data;
    assign address    = r_addr;
    assign byteenable = r_be;
    assign chipselect = r_cs;
    assign write      = r_write;
    assign writedata  = r_wdata;
    assign clken      = 1'b1;
`ifdef RAM_BIST_ERR_COUNT_EN
    assign err_count  = r_err_count;
`endif

    // Sequencer FSM, read-compare pipeline and error capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_base     <= '0;
            r_last     <= '0;
            r_seed     <= '0;
            r_remain   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cs       <= 1'b0;
            r_write    <= 1'b0;
            r_be       <= '0;
            r_err_addr <= '0;
            r_err_data <= '0;
            r_drain    <= '0;
            r_pipe_vld <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_pipe_addr[i] <= '0;
`ifdef RAM_BIST_ERR_COUNT_EN
            r_err_count <= '0;
`endif
        end else begin
            // expected-address pipeline, aligned with the RAM read latency
            r_pipe_vld[0]  <= r_cs & ~r_write;
            r_pipe_addr[0] <= r_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_addr[i] <= r_pipe_addr[i-1];
            end

            if (w_mismatch) begin
                r_error <= 1'b1;
                if (!r_error) begin
                    r_err_addr <= w_cmp_addr;
                    r_err_data <= readdata;
                end
`ifdef RAM_BIST_ERR_COUNT_EN
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
`endif
            end

            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_base     <= base_addr;
                        r_last     <= last_addr;
                        r_seed     <= seed;
                        r_remain   <= last_addr - base_addr;
                        r_addr     <= base_addr;
                        r_busy     <= 1'b1;
                        r_cs       <= 1'b1;
                        r_be       <= '1;
                        r_error    <= 1'b0;
                        r_err_addr <= '0;
                        r_err_data <= '0;
`ifdef RAM_BIST_ERR_COUNT_EN
                        r_err_count <= '0;
`endif
                        if (mode == 2'd1) begin
                            r_state <= S_READ;
                            r_write <= 1'b0;
                        end else begin
                            r_state <= S_WRITE;
                            r_write <= 1'b1;
                            r_wdata <= pattern(seed, base_addr);
                        end
                    end
                end
                S_WRITE: begin
                    if (r_remain == '0) begin
                        if (r_mode == 2'd2) begin
                            // read-back follows the last write with no idle cycle
                            r_state  <= S_READ;
                            r_write  <= 1'b0;
                            r_addr   <= r_base;
                            r_remain <= r_last - r_base;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_cs    <= 1'b0;
                            r_write <= 1'b0;
                            r_be    <= '0;
                        end
                    end else begin
                        r_remain <= r_remain - ADDR_W'(1);
                        r_addr   <= w_addr_inc;
                        r_wdata  <= pattern(r_seed, w_addr_inc);
                    end
                end
                S_READ: begin
                    if (r_remain == '0 || w_stop) begin
                        r_state <= S_DRAIN;
                        r_cs    <= 1'b0;
                        r_be    <= '0;
                        r_drain <= DRN_W'(READ_LATENCY - 1);
                    end else begin
                        r_remain <= r_remain - ADDR_W'(1);
                        r_addr   <= w_addr_inc;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - DRN_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed testbench for ram_bist_master with a 256 x 32 RAM model (read latency 1).
module tb_ram_bist_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  base_addr;
    logic [7:0]  last_addr;
    logic [31:0] seed;
    logic        busy, done, error;
    logic [7:0]  err_addr;
    logic [31:0] err_data;
`ifdef RAM_BIST_ERR_COUNT_EN
    logic [15:0] err_count;
`endif
    logic [7:0]  address;
    logic [3:0]  byteenable;
    logic        chipselect, write;
    logic [31:0] writedata;
    logic        clken;
    logic [31:0] readdata;

    logic [31:0] mem [256];
    logic        corrupt_req = 1'b0;
    logic [7:0]  corrupt_addr = 8'h00;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [7:0]  rd_addr_q [$];
    int          rd_cyc_q  [$];
    int          first_cs_cyc = -1;
    int          done_cyc = -1;
    int          done_cnt = 0;
    int          cs_runs = 0;
    int          be_bad = 0;
    int          err_rise_cyc = -1;
    logic        prev_cs = 1'b0;
    logic        prev_err = 1'b0;

    ram_bist_master #(.ADDR_W(8), .DATA_W(32), .READ_LATENCY(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_addr   (err_addr),
        .err_data   (err_data),
`ifdef RAM_BIST_ERR_COUNT_EN
        .err_count  (err_count),
`endif
        .address    (address),
        .byteenable (byteenable),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .clken      (clken),
        .readdata   (readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: write on the edge, read data valid one cycle after the address
    always @(posedge clk) begin
        if (chipselect === 1'b1 && write === 1'b1) mem[address] <= writedata;
        if (chipselect === 1'b1 && write === 1'b0) readdata <= mem[address];
        if (corrupt_req) mem[corrupt_addr] <= 32'h0;
    end

    // Bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (chipselect === 1'b1) begin
            if (first_cs_cyc < 0) first_cs_cyc = cyc;
            if (write === 1'b1) begin
                wr_addr_q.push_back(address);
                wr_data_q.push_back(writedata);
            end else begin
                rd_addr_q.push_back(address);
                rd_cyc_q.push_back(cyc);
            end
            if (prev_cs !== 1'b1) cs_runs++;
        end
        if ((chipselect === 1'b1 && byteenable !== 4'hF) ||
            (chipselect !== 1'b1 && byteenable !== 4'h0)) be_bad++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (error === 1'b1 && prev_err !== 1'b1) err_rise_cyc = cyc;
        prev_cs  = chipselect;
        prev_err = error;
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        first_cs_cyc = -1;
        done_cyc = -1;
        done_cnt = 0;
        cs_runs = 0;
        be_bad = 0;
        err_rise_cyc = -1;
    endtask

    task automatic start_op(input logic [1:0] m, input logic [7:0] b,
                            input logic [7:0] l, input logic [31:0] s);
        @(negedge clk);
        clear_logs();
        mode = m; base_addr = b; last_addr = l; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (chipselect !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_latency: cs=%b busy=%b expected cs=1 busy=1", chipselect, busy);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_vec++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: done not seen within 3000 cycles", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mode = 2'd0; base_addr = 8'h0; last_addr = 8'h0; seed = 32'h0;
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0)       begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
        n_vec++; if (error !== 1'b0)      begin n_bad++; $display("FAIL rst_error: got %b expected 0", error); end
        n_vec++; if (chipselect !== 1'b0) begin n_bad++; $display("FAIL rst_cs: got %b expected 0", chipselect); end
        n_vec++; if (write !== 1'b0)      begin n_bad++; $display("FAIL rst_write: got %b expected 0", write); end
        n_vec++; if (address !== 8'h0)    begin n_bad++; $display("FAIL rst_address: got %h expected 00", address); end
        n_vec++; if (err_addr !== 8'h0)   begin n_bad++; $display("FAIL rst_err_addr: got %h expected 00", err_addr); end
        n_vec++; if (err_data !== 32'h0)  begin n_bad++; $display("FAIL rst_err_data: got %h expected 0", err_data); end
        n_vec++; if (writedata !== 32'h0) begin n_bad++; $display("FAIL rst_writedata: got %h expected 0", writedata); end
        n_vec++; if (byteenable !== 4'h0) begin n_bad++; $display("FAIL rst_byteenable: got %h expected 0", byteenable); end
        n_vec++; if (clken !== 1'b1)      begin n_bad++; $display("FAIL rst_clken: got %b expected 1", clken); end
`ifdef RAM_BIST_ERR_COUNT_EN
        n_vec++; if (err_count !== 16'h0) begin n_bad++; $display("FAIL rst_err_count: got %h expected 0", err_count); end
`endif
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic test_fill();
        int bad;
        start_op(2'd0, 8'h00, 8'hFF, 32'h12345600);
        wait_done("fill");
        n_vec++; if (wr_addr_q.size() != 256) begin n_bad++; $display("FAIL fill_writes: got %0d expected 256", wr_addr_q.size()); end
        n_vec++; if (rd_addr_q.size() != 0)   begin n_bad++; $display("FAIL fill_reads: got %0d expected 0", rd_addr_q.size()); end
        n_vec++; if (cs_runs != 1)            begin n_bad++; $display("FAIL fill_contiguous: got %0d cs bursts expected 1", cs_runs); end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 8'(i) || wr_data_q[i] !== 32'h12345600 + 32'(i)) bad++;
        n_vec++; if (bad != 0) begin n_bad++; $display("FAIL fill_sequence: got %0d bad writes expected 0", bad); end
        n_vec++; if (mem[8'h10] !== 32'h12345610) begin n_bad++; $display("FAIL fill_ram10: got %h expected 12345610", mem[8'h10]); end
        n_vec++; if (mem[8'hFF] !== 32'h123456FF) begin n_bad++; $display("FAIL fill_ramFF: got %h expected 123456ff", mem[8'hFF]); end
        n_vec++; if (done_cyc - first_cs_cyc + 1 != 257) begin n_bad++; $display("FAIL fill_done_cycle: got %0d expected 257", done_cyc - first_cs_cyc + 1); end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL fill_done_count: got %0d expected 1", done_cnt); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fill_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_fill_verify();
        int bad;
        start_op(2'd2, 8'h00, 8'hFF, 32'hA5A50000);
        wait_done("fillverify");
        n_vec++; if (wr_addr_q.size() != 256) begin n_bad++; $display("FAIL fv_writes: got %0d expected 256", wr_addr_q.size()); end
        n_vec++; if (rd_addr_q.size() != 256) begin n_bad++; $display("FAIL fv_reads: got %0d expected 256", rd_addr_q.size()); end
        n_vec++; if (cs_runs != 1)            begin n_bad++; $display("FAIL fv_back_to_back: got %0d cs bursts expected 1", cs_runs); end
        bad = 0;
        for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] !== 8'(i)) bad++;
        for (int i = 0; i < 256; i++) if (mem[i] !== 32'hA5A50000 + 32'(i)) bad++;
        n_vec++; if (bad != 0) begin n_bad++; $display("FAIL fv_contents: got %0d bad entries expected 0", bad); end
        n_vec++; if (error !== 1'b0) begin n_bad++; $display("FAIL fv_error: got %b expected 0", error); end
        n_vec++; if (done_cyc - first_cs_cyc + 1 != 514) begin n_bad++; $display("FAIL fv_done_cycle: got %0d expected 514", done_cyc - first_cs_cyc + 1); end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL fv_done_count: got %0d expected 1", done_cnt); end
        n_vec++; if (be_bad != 0) begin n_bad++; $display("FAIL fv_byteenable: got %0d bad cycles expected 0", be_bad); end
    endtask

    task automatic test_verify_error();
        int idx;
        start_op(2'd0, 8'h00, 8'hFF, 32'h0);
        wait_done("fill0");
        @(negedge clk);
        corrupt_addr = 8'h42; corrupt_req = 1'b1;
        @(negedge clk);
        corrupt_req = 1'b0;
        start_op(2'd1, 8'h00, 8'hFF, 32'h0);
        wait_done("verify_err");
        n_vec++; if (error !== 1'b1)     begin n_bad++; $display("FAIL ve_error: got %b expected 1", error); end
        n_vec++; if (err_addr !== 8'h42) begin n_bad++; $display("FAIL ve_err_addr: got %h expected 42", err_addr); end
        n_vec++; if (err_data !== 32'h0) begin n_bad++; $display("FAIL ve_err_data: got %h expected 0", err_data); end
        n_vec++; if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL ve_writes: got %0d expected 0", wr_addr_q.size()); end
`ifdef RAM_BIST_ERR_COUNT_EN
        n_vec++; if (rd_addr_q.size() != 256) begin n_bad++; $display("FAIL ve_reads: got %0d expected 256", rd_addr_q.size()); end
        n_vec++; if (err_count !== 16'd1) begin n_bad++; $display("FAIL ve_err_count: got %0d expected 1", err_count); end
`else
        // the read of 0x43 is already on the bus when the 0x42 data is compared
        n_vec++; if (rd_addr_q.size() != 8'h44) begin n_bad++; $display("FAIL ve_reads: got %0d expected 68", rd_addr_q.size()); end
`endif
        idx = -1;
        for (int i = 0; i < rd_addr_q.size(); i++) if (rd_addr_q[i] === 8'h42 && idx < 0) idx = i;
        n_vec++;
        if (idx < 0 || err_rise_cyc != rd_cyc_q[idx] + 2) begin
            n_bad++;
            $display("FAIL ve_error_timing: got rise at %0d, read of 42 at index %0d", err_rise_cyc, idx);
        end
        n_vec++; if (done_cnt != 1) begin n_bad++; $display("FAIL ve_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [4];
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        start_op(2'd0, 8'hFE, 8'h01, 32'h0);
        n_vec++; if (error !== 1'b0 || err_addr !== 8'h0) begin n_bad++; $display("FAIL wrap_err_cleared: got error=%b err_addr=%h expected 0/00", error, err_addr); end
        wait_done("wrap");
        n_vec++; if (wr_addr_q.size() != 4) begin n_bad++; $display("FAIL wrap_writes: got %0d expected 4", wr_addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== exp_a[i] || wr_data_q[i] !== {24'h0, exp_a[i]}) begin
                n_bad++;
                $display("FAIL wrap_word%0d: expected addr %h data %h", i, exp_a[i], {24'h0, exp_a[i]});
            end
        end
        start_op(2'd3, 8'h37, 8'h37, 32'h100);
        wait_done("single");
        n_vec++; if (wr_addr_q.size() != 1) begin n_bad++; $display("FAIL single_writes: got %0d expected 1", wr_addr_q.size()); end
        n_vec++; if (mem[8'h37] !== 32'h137) begin n_bad++; $display("FAIL single_data: got %h expected 137", mem[8'h37]); end
    endtask

    task automatic test_start_while_busy();
        int bad;
        start_op(2'd0, 8'h20, 8'h2F, 32'h11110000);
        repeat (4) @(negedge clk);
        mode = 2'd1; base_addr = 8'h90; last_addr = 8'h95; seed = 32'h99990000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        n_vec++; if (wr_addr_q.size() != 16 || rd_addr_q.size() != 0) begin n_bad++; $display("FAIL busy_counts: got %0d writes %0d reads expected 16/0", wr_addr_q.size(), rd_addr_q.size()); end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (wr_addr_q[i] !== 8'h20 + 8'(i) || wr_data_q[i] !== 32'h11110020 + 32'(i)) bad++;
        n_vec++; if (bad != 0) begin n_bad++; $display("FAIL busy_pattern: got %0d bad writes expected 0", bad); end
        n_vec++; if (done_cnt != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL busy_done: got done_cnt=%0d busy=%b expected 1/0", done_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        start_op(2'd0, 8'h00, 8'hFF, 32'h5A000000);
        for (int i = 0; i < 50; i++) begin
            if (chipselect === 1'b1 && address === 8'h09) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++; if (!hit) begin n_bad++; $display("FAIL rmid_reach: tenth write not seen within 50 cycles"); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (chipselect !== 1'b0 || busy !== 1'b0 || write !== 1'b0) begin n_bad++; $display("FAIL rmid_abort: got cs=%b busy=%b write=%b expected 0/0/0", chipselect, busy, write); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++; if (done_cnt != 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_cnt); end
        n_vec++; if (wr_addr_q.size() != 10) begin n_bad++; $display("FAIL rmid_writes: got %0d expected 10", wr_addr_q.size()); end
        start_op(2'd0, 8'h80, 8'h83, 32'h7);
        wait_done("rmid_restart");
        n_vec++; if (wr_addr_q.size() != 4 || done_cnt != 1) begin n_bad++; $display("FAIL rmid_restart: got %0d writes %0d done expected 4/1", wr_addr_q.size(), done_cnt); end
        n_vec++; if (mem[8'h83] !== 32'h8A) begin n_bad++; $display("FAIL rmid_data: got %h expected 8a", mem[8'h83]); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_fill_verify();
        test_verify_error();
        test_wrap();
        test_start_while_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
